// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file: NUM_REGS word registers, byte-strobe writes, flat export.
// Optional feature macro: AXIL_SLV_DECERR_EN (DECERR for out-of-range, drop misaligned writes).
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int AW_LSB = $clog2(BYTES);
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] RESP_OOR        = 2'b11;
  localparam bit         DROP_MISALIGNED = 1'b1;
`else
  localparam logic [1:0] RESP_OOR        = RESP_SLVERR;
  localparam bit         DROP_MISALIGNED = 1'b0;
`endif

  typedef enum logic {WR_ACCEPT, WR_RESP} wrState_e;
  typedef enum logic {RD_IDLE, RD_DATA} rdState_e;

  wrState_e wrState_q, wrState_d;
  rdState_e rdState_q, rdState_d;

  logic                  awHeld_q, awHeld_d;
  logic                  wHeld_q, wHeld_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [DATA_WIDTH-1:0] wData_q, wData_d;
  logic [BYTES-1:0]      wStrb_q, wStrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  awHs, wHs, commit;
  logic [ADDR_WIDTH-1:0] curAddr, wrWord, rdWord;
  logic [DATA_WIDTH-1:0] curData;
  logic [BYTES-1:0]      curStrb;
  logic                  wrInRange, wrAligned, rdInRange;
  logic [IDX_W-1:0]      wrIdx, rdIdx;
  logic                  unusedProt;

  assign unusedProt = ^{AWPROT, ARPROT};

  assign AWREADY = (wrState_q == WR_ACCEPT) && !awHeld_q;
  assign WREADY  = (wrState_q == WR_ACCEPT) && !wHeld_q;
  assign ARREADY = (rdState_q == RD_IDLE);
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign awHs = AWVALID && AWREADY;
  assign wHs  = WVALID && WREADY;

  // A channel captured on this very edge is used directly, so the commit can coincide with it.
  assign curAddr   = awHeld_q ? awAddr_q : AWADDR;
  assign curData   = wHeld_q ? wData_q : WDATA;
  assign curStrb   = wHeld_q ? wStrb_q : WSTRB;
  assign wrWord    = curAddr >> AW_LSB;
  assign wrInRange = wrWord < ADDR_WIDTH'(NUM_REGS);
  assign wrAligned = (curAddr & ADDR_WIDTH'(BYTES - 1)) == '0;
  assign wrIdx     = wrWord[IDX_W-1:0];

  assign rdWord    = ARADDR >> AW_LSB;
  assign rdInRange = rdWord < ADDR_WIDTH'(NUM_REGS);
  assign rdIdx     = rdWord[IDX_W-1:0];

  always_comb begin
    wrState_d = wrState_q;
    awHeld_d  = awHeld_q;
    wHeld_d   = wHeld_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (wrState_q)
      WR_ACCEPT: begin
        if (awHs) begin
          awHeld_d = 1'b1;
          awAddr_d = AWADDR;
        end
        if (wHs) begin
          wHeld_d = 1'b1;
          wData_d = WDATA;
          wStrb_d = WSTRB;
        end
        if ((awHeld_q || awHs) && (wHeld_q || wHs)) begin
          wrState_d = WR_RESP;
          bvalid_d  = 1'b1;
          if (!wrInRange) begin
            bresp_d = RESP_OOR;
          end else if (DROP_MISALIGNED && !wrAligned) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d = RESP_OKAY;
            commit  = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          wrState_d = WR_ACCEPT;
          bvalid_d  = 1'b0;
          awHeld_d  = 1'b0;
          wHeld_d   = 1'b0;
        end
      end
      default: wrState_d = WR_ACCEPT;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (curStrb[b]) begin
          regs_d[wrIdx][b*8 +: 8] = curData[b*8 +: 8];
        end
      end
    end
  end

  // regs_q is sampled before this edge's commit, so a colliding read sees the old value.
  always_comb begin
    rdState_d = rdState_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (rdState_q)
      RD_IDLE: begin
        if (ARVALID) begin
          rdState_d = RD_DATA;
          rvalid_d  = 1'b1;
          if (rdInRange) begin
            rdata_d = regs_q[rdIdx];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_OOR;
          end
        end
      end
      RD_DATA: begin
        if (RREADY) begin
          rdState_d = RD_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: rdState_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wrState_q <= WR_ACCEPT;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rdState_q <= RD_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wrState_q <= wrState_d;
      awHeld_q  <= awHeld_d;
      wHeld_q   <= wHeld_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rdState_q <= rdState_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gExport
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (default 32-bit data, 16 registers).
// Expected responses follow the AXIL_SLV_DECERR_EN build option when it is defined.
module tb_axi_lite_slave_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
  localparam bit         STRICT   = 1'b1;
`else
  localparam logic [1:0] OOR_RESP = 2'b10;
  localparam bit         STRICT   = 1'b0;
`endif

  logic             ACLK;
  logic             ARESETn;
  logic [AW-1:0]    AWADDR;
  logic [2:0]       AWPROT;
  logic             AWVALID;
  logic             AWREADY;
  logic [DW-1:0]    WDATA;
  logic [DW/8-1:0]  WSTRB;
  logic             WVALID;
  logic             WREADY;
  logic [1:0]       BRESP;
  logic             BVALID;
  logic             BREADY;
  logic [AW-1:0]    ARADDR;
  logic [2:0]       ARPROT;
  logic             ARVALID;
  logic             ARREADY;
  logic [DW-1:0]    RDATA;
  logic [1:0]       RRESP;
  logic             RVALID;
  logic             RREADY;
  logic [NR*DW-1:0] reg_q;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] expReg [NR];

  axi_lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic nextCycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idleInputs();
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
  endtask

  task automatic writeWord(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, output logic bv, output logic [1:0] resp);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    nextCycle();
    AWVALID = 1'b0; WVALID = 1'b0;
    bv = BVALID;
    resp = BRESP;
    nextCycle();
    BREADY = 1'b0;
  endtask

  task automatic readWord(input logic [AW-1:0] addr, output logic rv,
                          output logic [DW-1:0] data, output logic [1:0] resp);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    nextCycle();
    ARVALID = 1'b0;
    rv = RVALID;
    data = RDATA;
    resp = RRESP;
    nextCycle();
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    ARESETn = 1'b1;
    #1;
    ARESETn = 1'b0;
    #12;
    for (int i = 0; i < NR; i++) expReg[i] = '0;
    checks++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1 || ARREADY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got aw=%0b w=%0b ar=%0b expected 1 1 1", AWREADY, WREADY, ARREADY);
    end
    checks++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got b=%0b r=%0b expected 0 0", BVALID, RVALID);
    end
    checks++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== '0) begin
      failures++;
      $display("[TB] FAIL reset_resp: got bresp=%0h rresp=%0h rdata=%0h expected 0 0 0", BRESP, RRESP, RDATA);
    end
    checks++;
    if (reg_q !== '0) begin
      failures++;
      $display("[TB] FAIL reset_regs: got nonzero reg_q expected all zero");
    end
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    nextCycle();
  endtask

  task automatic test_same_cycle_write();
    AWADDR = 32'h4; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    nextCycle();
    AWVALID = 1'b0; WVALID = 1'b0;
    expReg[1] = 32'hDEADBEEF;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      failures++;
      $display("[TB] FAIL same_cycle_b: got bvalid=%0b bresp=%0h expected 1 0", BVALID, BRESP);
    end
    checks++;
    if (reg_q[1*DW +: DW] !== expReg[1]) begin
      failures++;
      $display("[TB] FAIL same_cycle_reg1: got %08h expected %08h", reg_q[1*DW +: DW], expReg[1]);
    end
    checks++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL same_cycle_ready_drop: got aw=%0b w=%0b expected 0 0", AWREADY, WREADY);
    end
    nextCycle();
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL same_cycle_b_done: got bvalid=%0b aw=%0b w=%0b expected 0 1 1", BVALID, AWREADY, WREADY);
    end
  endtask

  task automatic test_w_before_aw();
    logic bv;
    logic [1:0] resp;
    int bCount;
    writeWord(32'h8, 32'hFFFFFFFF, 4'hF, bv, resp);
    expReg[2] = 32'hFFFFFFFF;
    checks++;
    if (bv !== 1'b1 || resp !== 2'b00 || reg_q[2*DW +: DW] !== expReg[2]) begin
      failures++;
      $display("[TB] FAIL prefill_reg2: got bv=%0b resp=%0h reg2=%08h expected 1 0 %08h", bv, resp, reg_q[2*DW +: DW], expReg[2]);
    end
    AWADDR = 32'h8; WDATA = 32'h11223344; WSTRB = 4'h5; WVALID = 1'b1; BREADY = 1'b1;
    nextCycle();
    WVALID = 1'b0;
    checks++;
    if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL w_first_hold: got w=%0b b=%0b aw=%0b expected 0 0 1", WREADY, BVALID, AWREADY);
    end
    bCount = 0;
    repeat (2) begin
      nextCycle();
      if (BVALID === 1'b1) bCount++;
    end
    AWVALID = 1'b1;
    nextCycle();
    AWVALID = 1'b0;
    expReg[2] = 32'hFF22FF44;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      failures++;
      $display("[TB] FAIL w_first_b: got bvalid=%0b bresp=%0h expected 1 0", BVALID, BRESP);
    end
    checks++;
    if (reg_q[2*DW +: DW] !== expReg[2]) begin
      failures++;
      $display("[TB] FAIL w_first_reg2: got %08h expected %08h", reg_q[2*DW +: DW], expReg[2]);
    end
    if (BVALID === 1'b1) bCount++;
    repeat (4) begin
      nextCycle();
      if (BVALID === 1'b1) bCount++;
    end
    BREADY = 1'b0;
    checks++;
    if (bCount != 1) begin
      failures++;
      $display("[TB] FAIL w_first_b_count: got %0d responses expected 1", bCount);
    end
  endtask

  task automatic test_read_backpressure();
    logic [DW-1:0] held;
    ARADDR = 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
    nextCycle();
    ARVALID = 1'b0;
    held = RDATA;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== expReg[1] || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_first: got rvalid=%0b rdata=%08h rresp=%0h ar=%0b expected 1 %08h 0 0", RVALID, RDATA, RRESP, ARREADY, expReg[1]);
    end
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      checks++;
      if (RVALID !== 1'b1 || RDATA !== expReg[1] || ARREADY !== 1'b0) begin
        failures++;
        $display("[TB] FAIL read_stall_%0d: got rvalid=%0b rdata=%08h ar=%0b expected 1 %08h 0", c, RVALID, RDATA, ARREADY, expReg[1]);
      end
    end
    RREADY = 1'b1;
    nextCycle();
    RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL read_release: got rvalid=%0b ar=%0b expected 0 1 (held %08h)", RVALID, ARREADY, held);
    end
  endtask

  task automatic test_wstrb_zero();
    logic bv;
    logic [1:0] resp;
    writeWord(32'h4, 32'h12345678, 4'h0, bv, resp);
    checks++;
    if (bv !== 1'b1 || resp !== 2'b00 || reg_q[1*DW +: DW] !== expReg[1]) begin
      failures++;
      $display("[TB] FAIL wstrb_zero: got bv=%0b resp=%0h reg1=%08h expected 1 0 %08h", bv, resp, reg_q[1*DW +: DW], expReg[1]);
    end
  endtask

  task automatic test_out_of_range();
    logic bv, rv;
    logic [1:0] resp;
    logic [DW-1:0] data;
    writeWord(32'h40, 32'hCAFEF00D, 4'hF, bv, resp);
    checks++;
    if (bv !== 1'b1 || resp !== OOR_RESP) begin
      failures++;
      $display("[TB] FAIL oor_write_resp: got bv=%0b bresp=%0h expected 1 %0h", bv, resp, OOR_RESP);
    end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (reg_q[i*DW +: DW] !== expReg[i]) begin
        failures++;
        $display("[TB] FAIL oor_reg%0d: got %08h expected %08h", i, reg_q[i*DW +: DW], expReg[i]);
      end
    end
    readWord(32'h40, rv, data, resp);
    checks++;
    if (rv !== 1'b1 || resp !== OOR_RESP || data !== '0) begin
      failures++;
      $display("[TB] FAIL oor_read: got rv=%0b rresp=%0h rdata=%08h expected 1 %0h 0", rv, resp, data, OOR_RESP);
    end
  endtask

  task automatic test_misaligned();
    logic bv, rv;
    logic [1:0] resp, expResp;
    logic [DW-1:0] data;
    writeWord(32'hD, 32'hA5A5A5A5, 4'hF, bv, resp);
    expResp = STRICT ? 2'b10 : 2'b00;
    if (!STRICT) expReg[3] = 32'hA5A5A5A5;
    checks++;
    if (bv !== 1'b1 || resp !== expResp || reg_q[3*DW +: DW] !== expReg[3]) begin
      failures++;
      $display("[TB] FAIL misaligned_write: got bv=%0b bresp=%0h reg3=%08h expected 1 %0h %08h", bv, resp, reg_q[3*DW +: DW], expResp, expReg[3]);
    end
    readWord(32'hE, rv, data, resp);
    checks++;
    if (rv !== 1'b1 || resp !== 2'b00 || data !== expReg[3]) begin
      failures++;
      $display("[TB] FAIL misaligned_read: got rv=%0b rresp=%0h rdata=%08h expected 1 0 %08h", rv, resp, data, expReg[3]);
    end
  endtask

  task automatic test_collision();
    logic bv, rv;
    logic [1:0] resp;
    logic [DW-1:0] data;
    writeWord(32'h0, 32'h1, 4'hF, bv, resp);
    expReg[0] = 32'h1;
    AWADDR = 32'h0; WDATA = 32'h5; WSTRB = 4'hF; ARADDR = 32'h0;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    nextCycle();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h1) begin
      failures++;
      $display("[TB] FAIL collision_old_data: got rvalid=%0b rdata=%08h expected 1 00000001", RVALID, RDATA);
    end
    expReg[0] = 32'h5;
    checks++;
    if (BVALID !== 1'b1 || reg_q[0 +: DW] !== expReg[0]) begin
      failures++;
      $display("[TB] FAIL collision_write: got bvalid=%0b reg0=%08h expected 1 %08h", BVALID, reg_q[0 +: DW], expReg[0]);
    end
    nextCycle();
    BREADY = 1'b0; RREADY = 1'b0;
    readWord(32'h0, rv, data, resp);
    checks++;
    if (rv !== 1'b1 || data !== 32'h5 || resp !== 2'b00) begin
      failures++;
      $display("[TB] FAIL collision_reread: got rv=%0b rdata=%08h rresp=%0h expected 1 00000005 0", rv, data, resp);
    end
  endtask

  task automatic test_reset_mid();
    AWADDR = 32'h14; WDATA = 32'h77; WSTRB = 4'hF; ARADDR = 32'h4;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
    nextCycle();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || RVALID !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_pre: got b=%0b r=%0b expected 1 1", BVALID, RVALID);
    end
    #2;
    ARESETn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) expReg[i] = '0;
    checks++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_async: got b=%0b r=%0b expected 0 0", BVALID, RVALID);
    end
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    nextCycle();
    checks++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1 || ARREADY !== 1'b1 || reg_q !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_after: got aw=%0b w=%0b ar=%0b regs_zero=%0b expected 1 1 1 1", AWREADY, WREADY, ARREADY, reg_q === '0);
    end
    AWADDR = 32'h8; AWVALID = 1'b1;
    nextCycle();
    AWVALID = 1'b0;
    checks++;
    if (AWREADY !== 1'b0 || BVALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL half_aw_held: got aw=%0b b=%0b expected 0 0", AWREADY, BVALID);
    end
    #2;
    ARESETn = 1'b0;
    #1;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    nextCycle();
    WDATA = 32'h99; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    nextCycle();
    WVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL half_aw_discarded: got b=%0b aw=%0b expected 0 1", BVALID, AWREADY);
    end
    AWADDR = 32'hC; AWVALID = 1'b1;
    nextCycle();
    AWVALID = 1'b0;
    expReg[3] = 32'h99;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      failures++;
      $display("[TB] FAIL post_reset_write_b: got bvalid=%0b bresp=%0h expected 1 0", BVALID, BRESP);
    end
    nextCycle();
    BREADY = 1'b0;
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (reg_q[i*DW +: DW] !== expReg[i]) begin
        failures++;
        $display("[TB] FAIL post_reset_reg%0d: got %08h expected %08h", i, reg_q[i*DW +: DW], expReg[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_read_backpressure();
    test_wstrb_zero();
    test_out_of_range();
    test_misaligned();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
